// File: rtl/counter_pkg.sv
// counter_pkg: direction constants and next-value arithmetic shared by counters
package counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic logic [32:0] next_count(input logic [32:0] count, input logic dir, input logic [32:0] modulus);
    return (dir == DIR_UP) ? ((count == modulus - 33'd1) ? 33'd0 : count + 33'd1)
                           : ((count == 33'd0) ? modulus - 33'd1 : count - 33'd1);
  endfunction
endpackage

// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if: control and status bundle of the up/down modulo counter
interface updown_mod_counter_if #(parameter int WIDTH = 4) ();
  logic en;
  logic up_dn;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic tc;
  logic wrap;
  logic load_err;
  modport master(output en, up_dn, load, load_val, input count, tc, wrap, load_err);
  modport slave(input en, up_dn, load, load_val, output count, tc, wrap, load_err);
endinterface

// File: rtl/mod_step.sv
// mod_step: next count value and terminal detect for one modulo step
module mod_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  output logic [WIDTH-1:0] nxt,
  output logic             at_term
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  logic [32:0] n;
  logic unused_hi;
  // arithmetic runs in 33 bits so MODULUS = 2^WIDTH never overflows
  always_comb begin
    n = next_count(33'(count), up_dn, 33'(MODULUS));
    nxt = n[WIDTH-1:0];
    unused_hi = ^n[32:WIDTH];
    at_term = count == ((up_dn == DIR_UP) ? LAST : '0);
  end
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: modulo-N up/down counter with load, terminal count and wrap pulse
module updown_mod_counter #(
  parameter int WIDTH = 4,
  parameter longint unsigned MODULUS = 16,
  parameter longint unsigned RESET_VAL = 0
) (
  input logic clk,
  input logic rst,
  updown_mod_counter_if.slave bus
);
  localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);
  if (RESET_VAL >= MODULUS || MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_param
    $error("updown_mod_counter: need 2 <= MODULUS <= 2^WIDTH and RESET_VAL < MODULUS");
  end
  logic [WIDTH-1:0] count_q, count_d, nxt;
  logic wrap_q, err_q, at_term, in_range;
  mod_step #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_step (
    .count(count_q),
    .up_dn(bus.up_dn),
    .nxt(nxt),
    .at_term(at_term)
  );
  // priority mux: load beats count, out-of-range loads clamp to the last value
  always_comb begin
    in_range = {1'b0, bus.load_val} < MOD_W;
    count_d = bus.load ? (in_range ? bus.load_val : LAST) : (bus.en ? nxt : count_q);
    bus.tc = bus.en & ~bus.load & at_term;
    bus.count = count_q;
    bus.wrap = wrap_q;
    bus.load_err = err_q;
  end
  // state registers; wrap is tc delayed one edge, load_err is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RV;
      wrap_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q <= bus.tc;
      err_q <= err_q | (bus.load & ~in_range);
    end
  end
endmodule
